// File: rtl/commit_gen_pkg.sv
// Shared types for the commit packet generator: packet layout, FSM states
// and small helpers that format FIFO entries and the forced-halt packet.
package commit_gen_pkg;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 65536;

    // One retired instruction as seen by the exit monitor.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic        mem;
        logic        halt;
        logic        ret;
    } commit_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    // Build a FIFO entry from writeback fields. The address is zeroed for
    // non-memory ops, and the return flag is only meaningful on the halt.
    function automatic commit_t make_entry(
        input logic [31:0] pc,
        input logic        is_mem,
        input logic [31:0] mem_addr,
        input logic        is_ebreak,
        input logic [31:0] a0
    );
        commit_t e;
        e.pc   = pc;
        e.mem  = is_mem;
        e.addr = is_mem ? mem_addr : 32'h0;
        e.halt = is_ebreak;
        e.ret  = is_ebreak && (a0 != 32'h0);
        return e;
    endfunction

    // Packet emitted when the watchdog gives up: a failing halt at the
    // last PC that made it into the block.
    function automatic commit_t make_timeout_halt(input logic [31:0] pc);
        commit_t e;
        e.pc   = pc;
        e.mem  = 1'b0;
        e.addr = 32'h0;
        e.halt = 1'b1;
        e.ret  = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/commit_gen_if.sv
// Writeback-in / commit-out bundle. The master side is the commit
// generator; the slave side is writeback plus the exit monitor.
interface commit_gen_if;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc;
    logic        wb_is_mem;
    logic [31:0] wb_mem_addr;
    logic        wb_is_ebreak;
    logic [31:0] wb_a0;

    logic        commit_commit;
    logic [31:0] commit_pc;
    logic        commit_mem;
    logic [31:0] commit_addr;
    logic        commit_halt;
    logic        commit_ret;
    logic        halted;

    modport master (
        input  wb_valid, wb_pc, wb_is_mem, wb_mem_addr, wb_is_ebreak, wb_a0,
        output wb_ready,
        output commit_commit, commit_pc, commit_mem, commit_addr,
        output commit_halt, commit_ret, halted
    );

    modport slave (
        output wb_valid, wb_pc, wb_is_mem, wb_mem_addr, wb_is_ebreak, wb_a0,
        input  wb_ready,
        input  commit_commit, commit_pc, commit_mem, commit_addr,
        input  commit_halt, commit_ret, halted
    );

endinterface

// File: rtl/commit_gen_fifo.sv
// Small circular buffer of commit entries. Head is presented combinationally;
// push is ignored when full and pop is ignored when empty.
module commit_fifo
    import commit_gen_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  commit_t din,
    input  logic    pop,
    output commit_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    commit_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the count MSB alone flags full.
    assign full  = count[PTR_W];
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Entry storage, written at the tail.
    // NOTE: the storage array has no reset; an empty count makes stale
    // contents unreachable, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; both pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/commit_gen.sv
// Commit packet generator: buffers retired instructions from writeback,
// emits one registered commit packet per cycle, tracks the halt instruction
// and forces a failing halt when writeback stops making progress.
module commit_gen
    import commit_gen_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input logic          clock,
    input logic          reset,
    commit_gen_if.master bus
);

    localparam int             WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [WD_W-1:0]   wdog_q;
    logic [31:0]       last_pc_q;

    commit_t           fifo_din;
    commit_t           fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    logic              wb_ready;
    logic              push;
    logic              pop;
    logic              fire_wd;

    commit_t           out_q;
    logic              commit_q;
    logic              halted_q;

    assign fifo_din = make_entry(bus.wb_pc, bus.wb_is_mem, bus.wb_mem_addr,
                                 bus.wb_is_ebreak, bus.wb_a0);

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake, pop/forced-halt decisions and next-state logic.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        wb_ready = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        fire_wd  = 1'b0;

        // Readiness looks only at registered state, never at this cycle's pop.
        wb_ready = (state_q == RUN) && !fifo_full;
        push     = bus.wb_valid && wb_ready;
        pop      = !fifo_empty && (state_q != HALTED);
        // The forced halt waits for queued entries so ordering is kept.
        fire_wd  = (state_q == RUN) && fifo_empty && !push && (wdog_q == WD_MAX);

        case (state_q)
            RUN: begin
                if (fire_wd) begin
                    state_d = HALTED;
                end else if (push && bus.wb_is_ebreak) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_head.halt) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // No-progress watchdog and last accepted PC for the forced-halt packet.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wdog_q    <= '0;
            last_pc_q <= 32'h0;
        end else if (push) begin
            wdog_q    <= '0;
            last_pc_q <= bus.wb_pc;
        end else if ((state_q == RUN) && (wdog_q != WD_MAX)) begin
            wdog_q    <= wdog_q + 1'b1;
        end
    end

    // Registered commit packet; fields hold between pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_q    <= '0;
            commit_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            commit_q <= pop || fire_wd;
            if (pop) begin
                out_q <= fifo_head;
            end else if (fire_wd) begin
                out_q <= make_timeout_halt(last_pc_q);
            end
            if ((pop && fifo_head.halt) || fire_wd) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.wb_ready      = wb_ready;
    assign bus.commit_commit = commit_q;
    assign bus.commit_pc     = out_q.pc;
    assign bus.commit_mem    = out_q.mem;
    assign bus.commit_addr   = out_q.addr;
    assign bus.commit_halt   = out_q.halt;
    assign bus.commit_ret    = out_q.ret;
    assign bus.halted        = halted_q;

endmodule
